// File: rtl/spi_des_pkg.sv
// rtl/spi_des_pkg.sv - opcodes, state encoding and status byte layout for spi_des_ctrl
package spi_des_pkg;

  localparam logic [7:0] CMD_KEY  = 8'hA1;
  localparam logic [7:0] CMD_ENC  = 8'hA2;
  localparam logic [7:0] CMD_DEC  = 8'hA3;
  localparam logic [7:0] CMD_READ = 8'hA4;
  localparam logic [7:0] CMD_STAT = 8'hA5;

  localparam int TIMEOUT_CYCLES = 4096;

  localparam logic [2:0] S_IDLE     = 3'd0;
  localparam logic [2:0] S_RX_KEY   = 3'd1;
  localparam logic [2:0] S_RX_DATA  = 3'd2;
  localparam logic [2:0] S_START    = 3'd3;
  localparam logic [2:0] S_WAIT_DES = 3'd4;
  localparam logic [2:0] S_TX_RES   = 3'd5;
  localparam logic [2:0] S_DRAIN    = 3'd6;

  localparam logic [3:0] STAT_SIG = 4'h5;
  localparam int STAT_BUSY_BIT = 7;
  localparam int STAT_RES_BIT  = 6;
  localparam int STAT_KEY_BIT  = 5;
  localparam int STAT_ERR_BIT  = 4;

  function automatic logic [7:0] status_byte(input logic busy, input logic res_valid,
                                             input logic key_valid, input logic err);
    logic [7:0] s;
    s = {4'h0, STAT_SIG};
    s[STAT_BUSY_BIT] = busy;
    s[STAT_RES_BIT]  = res_valid;
    s[STAT_KEY_BIT]  = key_valid;
    s[STAT_ERR_BIT]  = err;
    return s;
  endfunction

endpackage

// File: rtl/spi_des_ctrl_evt_sync.sv
// rtl/spi_des_ctrl_evt_sync.sv - spi_evt_sync: 2-flop synchroniser with registered rising-edge pulse
module spi_evt_sync #(
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk_i,
  input  logic rst_n_i,
  input  logic async_i,
  output logic level_o,
  output logic rise_o
);

  logic [1:0] sync_q;
  logic       prev_q;
  logic       rise_q;

  // Edge pulse is registered so every event lands 3 CLK after the input edge.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      sync_q <= {2{RST_VAL}};
      prev_q <= RST_VAL;
      rise_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[0], async_i};
      prev_q <= sync_q[1];
      rise_q <= sync_q[1] & ~prev_q;
    end
  end

  assign level_o = sync_q[1];
  assign rise_o  = rise_q;

endmodule

// File: rtl/spi_des_ctrl.sv
// rtl/spi_des_ctrl.sv - SPI command sequencer for the DES engine; SPI_CTRL_TIMEOUT_EN adds a stalled-frame abort
module spi_des_ctrl
  import spi_des_pkg::*;
(
  input  logic        CLK,
  input  logic        RST_N,
  input  logic        CS,
  input  logic [7:0]  recdata,
  input  logic        recflag,
  input  logic        senflag,
  output logic [7:0]  sendata,
  output logic        des_start,
  output logic        des_decrypt,
  output logic [63:0] des_key,
  output logic [63:0] des_din,
  input  logic [63:0] des_dout,
  input  logic        des_done,
  output logic        busy
);

  logic cs_lvl, cs_rise, rx_lvl, rx_ev, tx_lvl, tx_ev;

  spi_evt_sync #(.RST_VAL(1'b1)) u_cs_sync (
    .clk_i(CLK), .rst_n_i(RST_N), .async_i(CS), .level_o(cs_lvl), .rise_o(cs_rise)
  );
  spi_evt_sync #(.RST_VAL(1'b0)) u_rx_sync (
    .clk_i(CLK), .rst_n_i(RST_N), .async_i(recflag), .level_o(rx_lvl), .rise_o(rx_ev)
  );
  spi_evt_sync #(.RST_VAL(1'b0)) u_tx_sync (
    .clk_i(CLK), .rst_n_i(RST_N), .async_i(senflag), .level_o(tx_lvl), .rise_o(tx_ev)
  );

  logic        unused_lvl;
  assign unused_lvl = ^{rx_lvl, tx_lvl, cs_lvl};

  logic [2:0]  state_q, state_d;
  logic [3:0]  idx_q, idx_d;
  logic [63:0] stage_q, stage_d;
  logic [63:0] key_q, key_d;
  logic [63:0] din_q, din_d;
  logic [63:0] res_q, res_d;
  logic        dec_q, dec_d;
  logic        pend_dec_q, pend_dec_d;
  logic        busy_q, busy_d;
  logic        key_valid_q, key_valid_d;
  logic        res_valid_q, res_valid_d;
  logic        err_q, err_d;
  logic [7:0]  send_q, send_d;

  logic [63:0] stage_shift;
  logic [63:0] res_sh;
  logic [7:0]  status;

  assign stage_shift = {stage_q[55:0], recdata};
  assign res_sh      = res_q << {idx_q[2:0], 3'b000};
  assign status      = status_byte(busy_q, res_valid_q, key_valid_q, err_q);

`ifdef SPI_CTRL_TIMEOUT_EN
  logic [15:0] tmo_q, tmo_d;
  logic        tmo_run;
  assign tmo_run = !cs_lvl && (state_q != S_WAIT_DES) && (state_q != S_START) && (state_q != S_IDLE);
`endif

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q     <= S_IDLE;
      idx_q       <= 4'd0;
      stage_q     <= 64'd0;
      key_q       <= 64'd0;
      din_q       <= 64'd0;
      res_q       <= 64'd0;
      dec_q       <= 1'b0;
      pend_dec_q  <= 1'b0;
      busy_q      <= 1'b0;
      key_valid_q <= 1'b0;
      res_valid_q <= 1'b0;
      err_q       <= 1'b0;
      send_q      <= status_byte(1'b0, 1'b0, 1'b0, 1'b0);
`ifdef SPI_CTRL_TIMEOUT_EN
      tmo_q       <= 16'd0;
`endif
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      stage_q     <= stage_d;
      key_q       <= key_d;
      din_q       <= din_d;
      res_q       <= res_d;
      dec_q       <= dec_d;
      pend_dec_q  <= pend_dec_d;
      busy_q      <= busy_d;
      key_valid_q <= key_valid_d;
      res_valid_q <= res_valid_d;
      err_q       <= err_d;
      send_q      <= send_d;
`ifdef SPI_CTRL_TIMEOUT_EN
      tmo_q       <= tmo_d;
`endif
    end
  end

  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    stage_d     = stage_q;
    key_d       = key_q;
    din_d       = din_q;
    res_d       = res_q;
    dec_d       = dec_q;
    pend_dec_d  = pend_dec_q;
    busy_d      = busy_q;
    key_valid_d = key_valid_q;
    res_valid_d = res_valid_q;
    err_d       = err_q;
    send_d      = send_q;
`ifdef SPI_CTRL_TIMEOUT_EN
    tmo_d       = (tmo_run && !rx_ev) ? tmo_q + 16'd1 : 16'd0;
`endif

    if (cs_rise && state_q != S_START && state_q != S_WAIT_DES) begin
      state_d = S_IDLE;
      idx_d   = 4'd0;
      stage_d = 64'd0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (rx_ev) begin
            idx_d = 4'd0;
            case (recdata)
              CMD_KEY: state_d = S_RX_KEY;
              CMD_ENC, CMD_DEC: begin
                if (key_valid_q && !busy_q) begin
                  state_d    = S_RX_DATA;
                  pend_dec_d = (recdata == CMD_DEC);
                end else begin
                  err_d   = 1'b1;
                  state_d = S_DRAIN;
                end
              end
              CMD_READ: begin
                if (!res_valid_q) err_d = 1'b1;
                state_d = S_TX_RES;
              end
              CMD_STAT: begin
                err_d   = 1'b0;
                state_d = S_DRAIN;
              end
              default: begin
                err_d   = 1'b1;
                state_d = S_DRAIN;
              end
            endcase
          end
        end
        S_RX_KEY: begin
          if (rx_ev) begin
            stage_d = stage_shift;
            idx_d   = idx_q + 4'd1;
            if (idx_q == 4'd7) begin
              key_d       = stage_shift;
              key_valid_d = 1'b1;
              idx_d       = 4'd0;
              state_d     = S_DRAIN;
            end
          end
        end
        S_RX_DATA: begin
          if (rx_ev) begin
            stage_d = stage_shift;
            idx_d   = idx_q + 4'd1;
            // busy rises on entry to START so it is already high alongside des_start.
            if (idx_q == 4'd7) begin
              din_d       = stage_shift;
              dec_d       = pend_dec_q;
              busy_d      = 1'b1;
              res_valid_d = 1'b0;
              idx_d       = 4'd0;
              state_d     = S_START;
            end
          end
        end
        S_START: state_d = S_WAIT_DES;
        S_WAIT_DES: begin
          if (des_done) begin
            res_d       = des_dout;
            res_valid_d = 1'b1;
            busy_d      = 1'b0;
            state_d     = S_IDLE;
          end
        end
        S_TX_RES: begin
          // The last result byte stays in sendata until the following senflag,
          // which is when the slave has shifted it out.
          if (tx_ev) begin
            if (idx_q == 4'd8) begin
              idx_d   = 4'd0;
              state_d = S_DRAIN;
            end else begin
              send_d = res_sh[63:56];
              idx_d  = idx_q + 4'd1;
            end
          end
        end
        S_DRAIN: state_d = S_DRAIN;
        default: state_d = S_IDLE;
      endcase
`ifdef SPI_CTRL_TIMEOUT_EN
      if (tmo_run && !rx_ev && tmo_q == 16'(TIMEOUT_CYCLES - 1)) begin
        err_d   = 1'b1;
        idx_d   = 4'd0;
        state_d = S_DRAIN;
        tmo_d   = 16'd0;
      end
`endif
    end

    if (state_q != S_TX_RES) send_d = status;
  end

  always_comb begin
    des_start   = (state_q == S_START);
    des_decrypt = dec_q;
    des_key     = key_q;
    des_din     = din_q;
    busy        = busy_q;
    sendata     = send_q;
  end

endmodule
